// File: rtl/prestore_pack_pkg.sv
// Purpose: shared types and constants for the prestore sample packer and its correlator-side unpacker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prestore_pack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } prestore_pack_state_t;

    localparam int SAMPLES_PER_WORD = 8;
    localparam int BITS_PER_SAMPLE  = 4;
    localparam int WORD_WIDTH       = SAMPLES_PER_WORD * BITS_PER_SAMPLE;

    // Sample index counter: one count per sample slot in a word
    localparam int              IDX_WIDTH = 3;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = 3'd7;

    // Bit positions of each prestore bit inside a 4-bit sample nibble
    localparam int BIT_I_SIG = 0;
    localparam int BIT_I_MAG = 1;
    localparam int BIT_Q_SIG = 2;
    localparam int BIT_Q_MAG = 3;

    function automatic logic [BITS_PER_SAMPLE-1:0] pack_sample(
        input logic i_sig,
        input logic i_mag,
        input logic q_sig,
        input logic q_mag
    );
        logic [BITS_PER_SAMPLE-1:0] s;
        s            = '0;
        s[BIT_I_SIG] = i_sig;
        s[BIT_I_MAG] = i_mag;
        s[BIT_Q_SIG] = q_sig;
        s[BIT_Q_MAG] = q_mag;
        return s;
    endfunction

endpackage

// File: rtl/prestore_pack_stat.sv
// Purpose: counts I sign and I magnitude ones over every word written to sample RAM.
// Latency: counters reflect a written word one cycle after its write strobe.
// Backpressure: none; accepts a word every cycle, clear has priority over accumulate.
module prestore_pack_stat
    import prestore_pack_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    word_vld,
    input  logic [WORD_WIDTH-1:0]   word_dat,
    output logic [ADDR_WIDTH+3:0]   sig_ones,
    output logic [ADDR_WIDTH+3:0]   mag_ones
);

    logic [3:0] sig_cnt;
    logic [3:0] mag_cnt;

    // Population count of I sign / I magnitude bits across the eight samples of a word
    always_comb begin
        sig_cnt = '0;
        mag_cnt = '0;
        for (int k = 0; k < SAMPLES_PER_WORD; k++) begin
            sig_cnt = sig_cnt + {3'b000, word_dat[k*BITS_PER_SAMPLE+BIT_I_SIG]};
            mag_cnt = mag_cnt + {3'b000, word_dat[k*BITS_PER_SAMPLE+BIT_I_MAG]};
        end
    end

    // Accumulate per written word; a new arm restarts the statistics
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sig_ones <= '0;
            mag_ones <= '0;
        end else if (clear) begin
            sig_ones <= '0;
            mag_ones <= '0;
        end else if (word_vld) begin
            sig_ones <= sig_ones + {{ADDR_WIDTH{1'b0}}, sig_cnt};
            mag_ones <= mag_ones + {{ADDR_WIDTH{1'b0}}, mag_cnt};
        end
    end

endmodule

// File: rtl/prestore_pack.sv
// Purpose: packs epoch-aligned prestore sig/mag samples 8-per-word into sample RAM; PRESTORE_PACK_STAT_EN adds sig/mag statistics.
// Latency: write strobe one cycle after the 8th valid; done one cycle after the final write.
// Backpressure: none; accepts a sample every cycle, arm aborts any capture in progress.
module prestore_pack
    import prestore_pack_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ms_epoch,
    input  logic                    valid,
    input  logic                    I_sum_sig,
    input  logic                    I_sum_mag,
    input  logic                    Q_sum_sig,
    input  logic                    Q_sum_mag,
    input  logic                    arm,
    input  logic [ADDR_WIDTH:0]     len_words,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     words_written
`ifdef PRESTORE_PACK_STAT_EN
    ,
    output logic [ADDR_WIDTH+3:0]   sig_ones,
    output logic [ADDR_WIDTH+3:0]   mag_ones
`endif
);

    localparam int PACK_W = WORD_WIDTH - BITS_PER_SAMPLE;

    prestore_pack_state_t state, state_nxt;

    logic [ADDR_WIDTH:0]        len_q;
    logic [IDX_WIDTH-1:0]       idx;
    logic [PACK_W-1:0]          pack_q;     // first seven samples of the word in progress
    logic [BITS_PER_SAMPLE-1:0] sample;
    logic                       take;
    logic                       last_word;

    assign sample = pack_sample(I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag);

    // A sample counts in FILL, or in ARMED on the epoch cycle itself (it becomes sample 0)
    assign take = valid && !arm &&
                  ((state == FILL) || ((state == ARMED) && ms_epoch));

    // The write now on the bus completes the requested length
    assign last_word = mem_we &&
                       ((words_written + {{ADDR_WIDTH{1'b0}}, 1'b1}) == len_q);

    assign busy = (state == ARMED) || (state == FILL);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arm restarts from any state, zero length completes immediately
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = (len_words == '0) ? DONE : ARMED;
        end else begin
            case (state)
                ARMED:   if (ms_epoch)  state_nxt = FILL;
                FILL:    if (last_word) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath: shift samples in, emit a registered write on every 8th, advance address after the write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q         <= '0;
            idx           <= '0;
            pack_q        <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            words_written <= '0;
        end else begin
            mem_we <= 1'b0;
            if (arm) begin
                len_q         <= len_words;
                idx           <= '0;
                mem_addr      <= '0;
                words_written <= '0;
            end else begin
                if (take) begin
                    idx    <= idx + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                    pack_q <= {sample, pack_q[PACK_W-1:BITS_PER_SAMPLE]};
                    if (idx == LAST_IDX) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {sample, pack_q};
                    end
                end
                if (mem_we) begin
                    mem_addr      <= mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    words_written <= words_written + {{ADDR_WIDTH{1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef PRESTORE_PACK_STAT_EN
    prestore_pack_stat #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stat (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (arm),
        .word_vld (mem_we),
        .word_dat (mem_wdata),
        .sig_ones (sig_ones),
        .mag_ones (mag_ones)
    );
`endif

endmodule

// File: tb/tb_prestore_pack.sv
// Purpose: self-checking bench for prestore_pack: vector table, corner sequences, RAM-write scoreboard.
// Latency: expects write one cycle after the 8th valid and done one cycle after the last write.
// Backpressure: n/a; stat checks compile only with PRESTORE_PACK_STAT_EN.
module tb_prestore_pack;
    import prestore_pack_pkg::*;

    localparam int AW = 12;

    logic            clk;
    logic            resetn;
    logic            ms_epoch;
    logic            valid;
    logic            I_sum_sig;
    logic            I_sum_mag;
    logic            Q_sum_sig;
    logic            Q_sum_mag;
    logic            arm;
    logic [AW:0]     len_words;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            busy;
    logic            done;
    logic [AW:0]     words_written;
`ifdef PRESTORE_PACK_STAT_EN
    logic [AW+3:0]   sig_ones;
    logic [AW+3:0]   mag_ones;
`endif

    prestore_pack #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ms_epoch      (ms_epoch),
        .valid         (valid),
        .I_sum_sig     (I_sum_sig),
        .I_sum_mag     (I_sum_mag),
        .Q_sum_sig     (Q_sum_sig),
        .Q_sum_mag     (Q_sum_mag),
        .arm           (arm),
        .len_words     (len_words),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
`ifdef PRESTORE_PACK_STAT_EN
        ,
        .sig_ones      (sig_ones),
        .mag_ones      (mag_ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        int          len;
        logic        coinc;
        logic [63:0] smp;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;
    vec_t vecs[4];

    int sig_ref;
    int mag_ref;

    // Write monitor: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (resetn && mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%08h, no write expected", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid     = 1'b0;
        ms_epoch  = 1'b0;
        arm       = 1'b0;
        I_sum_sig = 1'b0;
        I_sum_mag = 1'b0;
        Q_sum_sig = 1'b0;
        Q_sum_mag = 1'b0;
    endtask

    task automatic drive_sample(input logic [3:0] n);
        valid     = 1'b1;
        I_sum_sig = n[0];
        I_sum_mag = n[1];
        Q_sum_sig = n[2];
        Q_sum_mag = n[3];
    endtask

    task automatic do_arm(input int len);
        idle_inputs();
        arm       = 1'b1;
        len_words = (AW+1)'(len);
        tick();
        arm = 1'b0;
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        sb.push_back(e);
    endtask

    // Finish phase: called while the final write is on the bus
    task automatic check_finish(input string tag, input int len);
        check({tag, "_done_during_last_write"}, done, 0);
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_words_written"}, words_written, len);
        check({tag, "_mem_addr"}, mem_addr, len % (1 << AW));
    endtask

    // Capture of up to two words from a 16-nibble sample vector
    task automatic run_capture(input int len, input logic coinc, input logic [63:0] smp,
                               input logic [31:0] exp0, input logic [31:0] exp1);
        do_arm(len);
        check("busy_after_arm", busy, 1);
        push_wr(0, exp0);
        if (len > 1) push_wr(1, exp1);
        if (!coinc) begin
            ms_epoch = 1'b1;
            tick();
            ms_epoch = 1'b0;
        end
        for (int i = 0; i < 8 * len; i++) begin
            drive_sample(smp[4*i +: 4]);
            ms_epoch = coinc && (i == 0);
            tick();
        end
        idle_inputs();
        check_finish("vec", len);
    endtask

    // Continuous random capture with model words built sample-by-sample
    task automatic run_random(input int words);
        logic [31:0] w;
        logic [3:0]  n;
        do_arm(words);
        sig_ref = 0;
        mag_ref = 0;
        for (int k = 0; k < words; k++) begin
            w = '0;
            for (int s = 0; s < 8; s++) begin
                n = 4'($urandom_range(0, 15));
                w[4*s +: 4] = n;
                sig_ref += int'(n[0]);
                mag_ref += int'(n[1]);
                drive_sample(n);
                ms_epoch = (k == 0) && (s == 0);
                if (s == 7) push_wr(k, w);
                tick();
            end
        end
        idle_inputs();
        check_finish("rand", words);
`ifdef PRESTORE_PACK_STAT_EN
        check("sig_ones", sig_ones, sig_ref);
        check("mag_ones", mag_ones, mag_ref);
`endif
    endtask

    initial begin
        vecs[0] = '{len: 2, coinc: 1'b0, smp: 64'h1111111111111111, exp0: 32'h11111111, exp1: 32'h11111111};
        vecs[1] = '{len: 1, coinc: 1'b1, smp: 64'h0000000076543210, exp0: 32'h76543210, exp1: 32'h0};
        vecs[2] = '{len: 2, coinc: 1'b1, smp: 64'h0F1E2D3C4B5A6978, exp0: 32'h4B5A6978, exp1: 32'h0F1E2D3C};
        vecs[3] = '{len: 1, coinc: 1'b0, smp: 64'h00000000C0FFEE42, exp0: 32'hC0FFEE42, exp1: 32'h0};

        resetn    = 1'b0;
        len_words = '0;
        idle_inputs();
        #23;
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_words_written", words_written, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Table-driven captures
        for (int v = 0; v < 4; v++) begin
            run_capture(vecs[v].len, vecs[v].coinc, vecs[v].smp, vecs[v].exp0, vecs[v].exp1);
        end

        // valid and ms_epoch in DONE are ignored
        ms_epoch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_sample(4'hF);
            tick();
            ms_epoch = 1'b0;
        end
        idle_inputs();
        tick();
        check("done_ignores_valid_ww", words_written, 1);
        check("done_held", done, 1);

        // Abort after 5 samples; pre-epoch and aborted samples must not leak into the next word
        do_arm(1);
        drive_sample(4'hF);
        tick();
        idle_inputs();
        ms_epoch = 1'b1;
        tick();
        ms_epoch = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_sample(4'hF);
            tick();
        end
        do_arm(1);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_words_written", words_written, 0);
        check("abort_busy", busy, 1);
        drive_sample(4'hA);
        tick();
        idle_inputs();
        ms_epoch = 1'b1;
        tick();
        push_wr(0, 32'hFEDCBA98);
        for (int i = 0; i < 8; i++) begin
            drive_sample(4'(8 + i));
            ms_epoch = (i == 3);
            tick();
        end
        idle_inputs();
        check_finish("abort", 1);

        // Zero length: done next cycle, never busy, no writes
        do_arm(0);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        ms_epoch = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_sample(4'h5);
            tick();
            ms_epoch = 1'b0;
            check("len0_busy_stays_low", busy, 0);
        end
        idle_inputs();
        check("len0_words_written", words_written, 0);

        // Random 64-word capture (statistics reference when enabled)
        run_random(64);

        // Full-RAM capture: address wraps to 0 at the end
        run_random(1 << AW);

        // Reset in the middle of a capture
        do_arm(3);
        ms_epoch = 1'b1;
        tick();
        ms_epoch = 1'b0;
        push_wr(0, 32'h33333333);
        for (int i = 0; i < 12; i++) begin
            drive_sample(4'h3);
            tick();
        end
        resetn = 1'b0;
        #2;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_mem_addr", mem_addr, 0);
        check("midreset_mem_wdata", mem_wdata, 0);
        check("midreset_words_written", words_written, 0);
        check("midreset_mem_we", mem_we, 0);
`ifdef PRESTORE_PACK_STAT_EN
        check("midreset_sig_ones", sig_ones, 0);
        check("midreset_mag_ones", mag_ones, 0);
`endif
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        tick();
        check("post_reset_idle_busy", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prestore_pack.md
# prestore_pack

Receiver/consumer for the prestore output stream. Captures the 4-bit-per-sample sig/mag stream (I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag qualified by `valid`) starting on a millisecond epoch. Packs eight samples per 32-bit word and writes a configured number of words into the acquisition sample RAM. Sits between prestore and the correlator's sample memory in the acquisition path.

## Interface
- ADDR_WIDTH, 12, sample-RAM word address width
- clk  in  1  frontend sample clock (same domain as prestore)
- resetn  in  1  asynchronous, active-low reset
- ms_epoch  in  1  one-cycle millisecond epoch strobe
- valid  in  1  prestore output strobe; qualifies the four sample bits
- I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag  in  1 each  prestore sample bits
- arm  in  1  one-cycle pulse: latch len_words, start waiting for ms_epoch
- len_words  in  ADDR_WIDTH+1  number of words to capture (0..2^ADDR_WIDTH)
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  32  packed word
- busy  out  1  high in ARMED or FILL
- done  out  1  high in DONE; held until next arm
- words_written  out  ADDR_WIDTH+1  words written in the current/last capture
- sig_ones, mag_ones  out  ADDR_WIDTH+4 each  statistics; exist only with PRESTORE_PACK_STAT_EN

## Operation
- States: IDLE, ARMED, FILL, DONE.
- IDLE/DONE + arm → latch len_words, clear words_written, mem_addr, the sample index and stat counters → ARMED. If the latched len = 0, go directly to DONE instead.
- ARMED + ms_epoch → FILL. If valid is high on the same cycle as ms_epoch, that sample is sample 0.
- FILL: each valid shifts one sample into the pack register. Sample k (0 = oldest) of a word occupies bits [4k+3:4k] = {Q_sum_mag, Q_sum_sig, I_sum_mag, I_sum_sig}.
- Word completes on the 8th valid. Then:
  - mem_we pulses once, with mem_wdata = the packed word and mem_addr = current address.
  - mem_addr increments after the write (wraps at 2^ADDR_WIDTH only when len = 2^ADDR_WIDTH, ending at 0).
  - words_written increments.
- When words_written reaches the latched len → DONE. Further valid strobes are ignored.
- arm in ARMED or FILL aborts the capture. The partial word is discarded, with no write, and the restart follows the IDLE rules. ms_epoch outside ARMED is ignored.
- valid outside FILL is ignored. Additional ms_epoch pulses in FILL do not resynchronise.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0, stats=0, state=IDLE, sample index 0.
- arm → busy high the next cycle. ms_epoch at cycle t → state FILL at t+1, capturing valid from cycle t onward.
- 8th valid at cycle t → mem_we high at t+1 (registered). mem_addr/mem_wdata are valid in the same cycle as mem_we.
- Back-to-back valid every cycle is supported: one word every 8 cycles, no stall.
- done rises in the cycle after the final mem_we. busy falls in that same cycle.
- Reset mid-capture: immediate return to reset values. RAM contents are untouched.

## Configuration
- PRESTORE_PACK_STAT_EN defined:
  - sig_ones counts captured samples with I_sum_sig=1; mag_ones counts those with I_sum_mag=1.
  - Both count only samples belonging to written words, update with mem_we and are cleared on arm.
  - This gives the sig/mag distribution check for the quantizer thresholds.
- Not defined: the ports are absent and no counter logic is generated.

## Structure
- Shared package prestore_pack_pkg:
  - state enum prestore_pack_state_t;
  - SAMPLES_PER_WORD=8, BITS_PER_SAMPLE=4, WORD_WIDTH=32;
  - sample bit-order localparams shared with the correlator-side unpacker.
- One sub-module, prestore_pack_stat, holds the two statistics counters and is instantiated only under PRESTORE_PACK_STAT_EN. Everything else lives in the top module.

## Test plan
- len_words=2, arm, ms_epoch, then 16 valid cycles with I_sig=1 and other bits 0:
  - expect two mem_we at addr 0 and 1, wdata 32'h11111111 each;
  - done=1 one cycle after the second write; words_written=2.
- valid with pattern sample k = k[3:0] and ms_epoch coincident with the first valid:
  - expect wdata 32'h76543210, so that first sample is included.
- arm after 5 valid in FILL:
  - expect no write and mem_addr back to 0;
  - the next capture's first word is built from post-epoch samples only.
- len_words=0:
  - arm → done next cycle, no mem_we, busy never high.
- len_words=2^ADDR_WIDTH with continuous valid:
  - expect 2^ADDR_WIDTH writes, final mem_addr wraps to 0, and done.
- With PRESTORE_PACK_STAT_EN and random sig/mag over 64 words:
  - sig_ones and mag_ones equal reference counts of the written samples.
- Without the macro: the bench compiles with the stat ports absent.
